// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg
// Shared constants, types and helpers for the quad-ADC sample packer.
//   ADC_BITS      raw offset-binary sample width per channel
//   NUM_CHANNELS  channels packed into one stream word
//   LANE_BITS     width of one sign-extended lane in the stream word
//   WORD_BITS     AXI-Stream TDATA width
//   state_e       capture control states
//   fifo_entry_t  one FIFO slot: packed word plus its TLAST flag
// ---------------------------------------------------------------------------
package adc_pkg;

  localparam int ADC_BITS     = 14;
  localparam int NUM_CHANNELS = 4;
  localparam int LANE_BITS    = 16;
  localparam int WORD_BITS    = 64;

  typedef logic [ADC_BITS-1:0]  adc_t;
  typedef logic [LANE_BITS-1:0] lane_t;
  typedef logic [WORD_BITS-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic  last;
    word_t data;
  } fifo_entry_t;

  // Offset binary -> two's complement is a flip of the MSB; the flipped MSB
  // is then the sign bit and is replicated into the extra lane bits.
  function automatic lane_t adc_to_lane(input adc_t raw);
    logic sign;
    sign = ~raw[ADC_BITS-1];
    return {{(LANE_BITS - ADC_BITS + 1){sign}}, raw[ADC_BITS-2:0]};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered first-word-fall-through output.
// Capacity is DEPTH words in total, counting the word held in the output
// register. A word pushed at edge N reaches the output register at edge N+1.
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        push request (ignored while full)
//   wr_data      push data
//   full         occupancy == DEPTH (pre-pop; a same-cycle pop frees nothing)
//   rd_valid     output register holds a word
//   rd_data      head word, stable while rd_valid && !rd_ready
//   rd_ready     consumer accepts the head word this cycle
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  logic             push;
  logic             pop;
  logic             load;
  logic [CW-1:0]    ram_count;

  // NOTE: every signal written here gets a default at the top of the block;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    push        = wr_en && !full;
    pop         = out_valid_q && rd_ready;
    // Words still waiting in RAM, i.e. not yet moved into the output register.
    ram_count   = count_q - CW'(out_valid_q);
    // Refill the output register when it is empty or being emptied. RAM words
    // written this very edge are not counted, which gives the one-edge
    // write-to-output latency.
    load        = (ram_count != '0) && (!out_valid_q || pop);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q + CW'(push) - CW'(pop);

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (load) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and
  // count define which slots are live, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_valid = out_valid_q;
  assign rd_data  = out_data_q;

endmodule

// File: rtl/adc_sample_packer.sv
// ---------------------------------------------------------------------------
// adc_sample_packer
// Converts four offset-binary ADC channels to sign-extended 16-bit lanes,
// packs them into one 64-bit word per sample strobe and streams the words
// out over AXI-Stream in fixed-length packets (TLAST every PACKET_WORDS).
//   ACLK, ARESETN      clock, asynchronous active-low reset
//   ENABLE             software capture enable
//   SAMPLE_VALID       one-cycle strobe: CH_*_DATA hold a new sample
//   CH_[A-D]_DATA      14-bit offset-binary channel samples
//   M_AXIS_*           AXI-Stream master (TDATA/TVALID/TREADY/TLAST)
//   OVERFLOW_COUNT     samples dropped on a full FIFO, saturating
//   BUSY               capture active (RUN or DRAIN)
// Disabling mid-packet finishes the packet (DRAIN) so downstream never sees
// a truncated packet.
// ---------------------------------------------------------------------------
module adc_sample_packer
  import adc_pkg::*;
#(
  parameter int PACKET_WORDS = 512,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 ENABLE,
  input  logic                 SAMPLE_VALID,
  input  logic [ADC_BITS-1:0]  CH_A_DATA,
  input  logic [ADC_BITS-1:0]  CH_B_DATA,
  input  logic [ADC_BITS-1:0]  CH_C_DATA,
  input  logic [ADC_BITS-1:0]  CH_D_DATA,
  output logic [WORD_BITS-1:0] M_AXIS_TDATA,
  output logic                 M_AXIS_TVALID,
  input  logic                 M_AXIS_TREADY,
  output logic                 M_AXIS_TLAST,
  output logic [15:0]          OVERFLOW_COUNT,
  output logic                 BUSY
);

  localparam logic [15:0] LAST_IDX = 16'(PACKET_WORDS - 1);

  state_e      state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] ovf_cnt_q, ovf_cnt_d;

  logic        capturing;
  logic        wr_accept;
  logic        drop;
  logic        word_last;
  logic        fifo_full;
  fifo_entry_t wr_entry;
  fifo_entry_t rd_entry;

  always_comb begin
    capturing = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    wr_accept = SAMPLE_VALID && capturing && !fifo_full;
    drop      = SAMPLE_VALID && capturing && fifo_full;
    word_last = (word_cnt_q == LAST_IDX);

    wr_entry.data = {adc_to_lane(CH_D_DATA), adc_to_lane(CH_C_DATA),
                     adc_to_lane(CH_B_DATA), adc_to_lane(CH_A_DATA)};
    wr_entry.last = word_last;

    // Only accepted words advance the packet position; drops do not, so
    // a packet never contains a hole.
    word_cnt_d = word_cnt_q;
    if (wr_accept) begin
      word_cnt_d = word_last ? 16'd0 : word_cnt_q + 16'd1;
    end

    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_d = ovf_cnt_q + 16'd1;
    end

    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Decide on the post-write position: a word accepted in this same
        // cycle opens a packet that must still be completed.
        if (!ENABLE) state_d = (word_cnt_d != 16'd0) ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (ENABLE)                      state_d = ST_RUN;
        else if (wr_accept && word_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_IDLE;
      word_cnt_q <= '0;
      ovf_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .wr_en    (wr_accept),
    .wr_data  (wr_entry),
    .full     (fifo_full),
    .rd_valid (M_AXIS_TVALID),
    .rd_data  (rd_entry),
    .rd_ready (M_AXIS_TREADY)
  );

  assign M_AXIS_TDATA   = rd_entry.data;
  assign M_AXIS_TLAST   = rd_entry.last;
  assign OVERFLOW_COUNT = ovf_cnt_q;
  assign BUSY           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adc_sample_packer.sv
// ---------------------------------------------------------------------------
// tb_adc_sample_packer
// Directed bench for adc_sample_packer (PACKET_WORDS=4, FIFO_DEPTH=4).
// A queue-based model predicts the stream; a compare process checks every
// output on every falling edge; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_adc_sample_packer;

  localparam int PW    = 4;
  localparam int DEPTH = 4;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic        ENABLE;
  logic        SAMPLE_VALID;
  logic [13:0] ch_a, ch_b, ch_c, ch_d;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [15:0] ovf_count;
  logic        busy;

  adc_sample_packer #(
    .PACKET_WORDS (PW),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .ENABLE         (ENABLE),
    .SAMPLE_VALID   (SAMPLE_VALID),
    .CH_A_DATA      (ch_a),
    .CH_B_DATA      (ch_b),
    .CH_C_DATA      (ch_c),
    .CH_D_DATA      (ch_d),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TREADY  (tready),
    .M_AXIS_TLAST   (tlast),
    .OVERFLOW_COUNT (ovf_count),
    .BUSY           (busy)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- model ----------------
  typedef struct {
    logic [63:0] data;
    logic        last;
    int          wr_edge;
  } exp_word_t;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } seen_t;

  exp_word_t exp_q[$];
  seen_t     out_log[$];

  int n_vec  = 0;
  int n_err  = 0;
  int edge_n = 0;
  int m_mode = 0;   // 0 idle, 1 capturing, 2 finishing a packet after disable
  int m_pos  = 0;   // words already written in the current packet
  int m_ovf  = 0;

  logic        prev_valid = 1'b0;
  logic [63:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  // Offset binary minus mid-scale is the signed value.
  function automatic logic [15:0] lane(input logic [13:0] raw);
    int v;
    v = int'(raw) - 8192;
    return 16'(v);
  endfunction

  // The oldest unconsumed word is on the bus once one edge has passed since
  // it was written.
  function automatic bit head_visible();
    return (exp_q.size() > 0) && (exp_q[0].wr_edge <= edge_n - 1);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mode = 0;
    m_pos  = 0;
    m_ovf  = 0;
  endtask

  // Model advance at each rising edge.
  initial begin : model_proc
    bit pop, wr, was_last;
    forever begin
      @(posedge ACLK);
      if (ARESETN) begin
        if (prev_valid && tready) out_log.push_back('{data: prev_data, last: prev_last});
        pop = head_visible() && tready;
        wr  = 1'b0;
        was_last = 1'b0;
        if (SAMPLE_VALID && m_mode != 0) begin
          if (exp_q.size() < DEPTH) wr = 1'b1;
          else if (m_ovf < 65535) m_ovf++;
        end
        edge_n++;
        if (pop) void'(exp_q.pop_front());
        if (wr) begin
          was_last = (m_pos == PW - 1);
          exp_q.push_back('{data: {lane(ch_d), lane(ch_c), lane(ch_b), lane(ch_a)},
                            last: was_last, wr_edge: edge_n});
          m_pos = (m_pos + 1) % PW;
        end
        case (m_mode)
          0: if (ENABLE) m_mode = 1;
          1: if (!ENABLE) m_mode = (m_pos != 0) ? 2 : 0;
          default: begin
            if (ENABLE) m_mode = 1;
            else if (was_last) m_mode = 0;
          end
        endcase
      end else begin
        edge_n++;
      end
    end
  end

  // Compare on every falling edge.
  initial begin : compare_proc
    bit ev;
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        check("rst_tvalid", 64'(tvalid), 64'd0);
        check("rst_tdata", tdata, 64'd0);
        check("rst_tlast", 64'(tlast), 64'd0);
        check("rst_ovf", 64'(ovf_count), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        prev_valid = 1'b0;
      end else begin
        ev = head_visible();
        check("tvalid", 64'(tvalid), 64'(ev));
        if (ev && tvalid) begin
          check("tdata", tdata, exp_q[0].data);
          check("tlast", 64'(tlast), 64'(exp_q[0].last));
        end
        check("ovf", 64'(ovf_count), 64'(m_ovf));
        check("busy", 64'(busy), 64'(m_mode != 0));
        prev_valid = tvalid;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  task automatic strobe(input logic [13:0] v);
    SAMPLE_VALID = 1'b1;
    ch_a = v; ch_b = v; ch_c = v; ch_d = v;
    tick();
    SAMPLE_VALID = 1'b0;
  endtask

  task automatic pulse_reset();
    ARESETN = 1'b0;
    model_reset();
    #1;
    check("async_rst_tvalid", 64'(tvalid), 64'd0);
    check("async_rst_tdata", tdata, 64'd0);
    check("async_rst_ovf", 64'(ovf_count), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    tick();
    ARESETN = 1'b1;
    out_log.delete();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed scenarios ----------------
  initial begin : stim
    ARESETN = 1'b1; ENABLE = 1'b0; SAMPLE_VALID = 1'b0; tready = 1'b0;
    ch_a = '0; ch_b = '0; ch_c = '0; ch_d = '0;
    #1;
    pulse_reset();
    tick();

    // Conversion and latency.
    ENABLE = 1'b1; tready = 1'b1;
    tick();
    check("run_busy", 64'(busy), 64'd1);
    SAMPLE_VALID = 1'b1;
    ch_a = 14'h2AAA; ch_b = 14'h2BBB; ch_c = 14'h0000; ch_d = 14'h3FFF;
    tick();
    SAMPLE_VALID = 1'b0;
    check("lat_not_yet", 64'(tvalid), 64'd0);
    tick();
    check("conv_tvalid", 64'(tvalid), 64'd1);
    check("conv_tdata", tdata, 64'h1FFF_E000_0BBB_0AAA);
    check("conv_tlast", 64'(tlast), 64'd0);
    tick();
    pulse_reset();

    // TLAST period: 9 words, TLAST on the 4th and 8th.
    ENABLE = 1'b1; tready = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) strobe(14'(i));
    repeat (4) tick();
    check("tlast_count", 64'(out_log.size()), 64'd9);
    for (int i = 0; i < 9 && i < out_log.size(); i++) begin
      check($sformatf("tlast_w%0d", i + 1), 64'(out_log[i].last), 64'((i == 3) || (i == 7)));
      check($sformatf("tlast_d%0d", i + 1), out_log[i].data, {4{16'hE000 + 16'(i)}});
    end
    pulse_reset();

    // Overflow: 6 strobes into a 4-deep FIFO with the sink stalled.
    ENABLE = 1'b1; tready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) strobe(14'(10 + i));
    repeat (2) tick();
    check("ovf_count", 64'(ovf_count), 64'd2);
    check("ovf_hold_valid", 64'(tvalid), 64'd1);
    check("ovf_hold_data", tdata, {4{16'hE00A}});
    tready = 1'b1;
    repeat (6) tick();
    check("ovf_out_count", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      check($sformatf("ovf_order%0d", i), out_log[i].data, {4{16'hE000 + 16'(10 + i)}});
    check("ovf_kept", 64'(ovf_count), 64'd2);
    check("ovf_empty", 64'(tvalid), 64'd0);

    // Reset with 3 words queued mid-packet.
    tready = 1'b0;
    out_log.delete();
    for (int i = 0; i < 3; i++) strobe(14'(30 + i));
    tick();
    check("pre_rst_valid", 64'(tvalid), 64'd1);
    pulse_reset();
    tready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) strobe(14'(20 + i));
    repeat (4) tick();
    check("post_rst_count", 64'(out_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      check($sformatf("post_rst_last%0d", i), 64'(out_log[i].last), 64'(i == 3));
    pulse_reset();

    // Drain: disable after 2 words, packet still completes.
    ENABLE = 1'b1; tready = 1'b1;
    tick();
    strobe(14'd40);
    strobe(14'd41);
    ENABLE = 1'b0;
    tick();
    check("drain_busy", 64'(busy), 64'd1);
    strobe(14'd42);
    strobe(14'd43);
    check("drain_idle", 64'(busy), 64'd0);
    strobe(14'd44);
    strobe(14'd45);
    repeat (4) tick();
    check("drain_count", 64'(out_log.size()), 64'd4);
    if (out_log.size() == 4) begin
      check("drain_last", 64'(out_log[3].last), 64'd1);
      check("drain_mid", 64'(out_log[1].last), 64'd0);
      check("drain_data", out_log[3].data, {4{16'hE02B}});
    end
    check("drain_quiet", 64'(tvalid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adc_sample_packer.md
ADC_SAMPLE_PACKER -- requirements
Module: adc_sample_packer

Interface
REQ-001 SHALL have parameter PACKET_WORDS, default 512, giving output words per packet (TLAST period), range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving the output FIFO depth in words, power of two, at least 4.
REQ-003 ACLK  input  1  sole clock; every register is clocked on its rising edge.
REQ-004 ARESETN  input  1  asynchronous, active-low reset.
REQ-005 ENABLE  input  1  capture enable from software control.
REQ-006 SAMPLE_VALID  input  1  one-cycle strobe: a new 4-channel sample is present on the CH_*_DATA inputs.
REQ-007 CH_A_DATA, CH_B_DATA, CH_C_DATA, CH_D_DATA  input  14 each  offset-binary ADC samples from the quad ADC deserializer.
REQ-008 M_AXIS_TDATA  output  64  packed sample word.
REQ-009 M_AXIS_TVALID  output  1  AXI-Stream valid.
REQ-010 M_AXIS_TREADY  input  1  AXI-Stream ready.
REQ-011 M_AXIS_TLAST  output  1  marks the final word of a packet.
REQ-012 OVERFLOW_COUNT  output  16  count of samples dropped because the FIFO was full; saturates at 16'hFFFF.
REQ-013 BUSY  output  1  high in RUN or DRAIN state.

Function
REQ-014 Each channel SHALL be converted to two's complement by inverting bit 13, then sign-extended to 16 bits.
REQ-015 Packing SHALL be: A in TDATA[15:0], B in [31:16], C in [47:32], D in [63:48].
REQ-016 A sample SHALL be written only when SAMPLE_VALID is high, the state is RUN or DRAIN, and the FIFO is not full.
REQ-017 The full check SHALL use the pre-read occupancy; a pop in the same cycle does not free space for that cycle's write.
REQ-018 A sample offered while the FIFO is full SHALL be dropped, SHALL increment OVERFLOW_COUNT (saturating), and SHALL NOT advance the word counter.
REQ-019 Word counter SHALL count written words, 0..PACKET_WORDS-1; the word written at count PACKET_WORDS-1 SHALL carry TLAST=1 in the FIFO; the counter then wraps to 0.
REQ-020 Latency: a sample written at edge N into an empty FIFO SHALL present TVALID=1 with its data after edge N+1.
REQ-021 A word SHALL leave the FIFO only when TVALID and TREADY are both high; TDATA/TLAST SHALL be stable while TVALID=1 and TREADY=0.
REQ-022 State machine has three states, IDLE, RUN and DRAIN:
  - IDLE: no writes.
  - IDLE -> RUN when ENABLE=1.
  - RUN -> DRAIN when ENABLE=0 and the word counter is not 0.
  - RUN -> IDLE when ENABLE=0 and the word counter is 0.
  - DRAIN: keeps capturing until the TLAST word is written, then goes to IDLE.
  - DRAIN -> RUN when ENABLE returns to 1.
REQ-023 Packets SHALL always be complete: software disable never truncates a packet in the FIFO.
REQ-024 OVERFLOW_COUNT SHALL clear only on reset.

Reset
REQ-025 On ARESETN=0, asynchronously: state=IDLE, word counter=0, FIFO empty, TVALID=0, TLAST=0, TDATA=0, OVERFLOW_COUNT=0, BUSY=0.
REQ-026 Reset mid-packet SHALL discard FIFO contents and the partial packet; the first word after reset starts a new packet.
REQ-027 Outputs SHALL stay at their reset values until the first rising ACLK edge after ARESETN rises.

Structure
REQ-028 Shared package adc_pkg SHALL hold ADC_BITS=14, NUM_CHANNELS=4, LANE_BITS=16, WORD_BITS=64, and the state enumeration.
REQ-029 The FIFO SHALL be a separate sub-module, sync_fifo (parameterised width and depth, registered first-word-fall-through output); packing and control SHALL stay in adc_sample_packer.

Verification
REQ-030 Conversion: A=14'h2AAA, B=14'h2BBB, C=14'h0000, D=14'h3FFF with ENABLE=1 and TREADY=1 -> TDATA=64'h1FFF_E000_0BBB_0AAA one cycle after the strobe.
REQ-031 TLAST: PACKET_WORDS=4, 9 strobes with TREADY=1 -> TLAST=1 on words 4 and 8 only.
REQ-032 Overflow: FIFO_DEPTH=4, TREADY=0, 6 strobes -> 4 words held, OVERFLOW_COUNT=2; then TREADY=1 -> 4 words out in order, unchanged.
REQ-033 Drain: PACKET_WORDS=4, ENABLE falls after 2 words written -> 2 more strobes captured, the 4th word has TLAST, state IDLE, BUSY=0, further strobes ignored.
REQ-034 Reset: ARESETN pulsed low with 3 words queued -> TVALID=0 immediately, OVERFLOW_COUNT=0; next packet's TLAST on its PACKET_WORDS-th word.
